// File: rtl/sgd_pkg.sv
// Shared types and arithmetic helpers for the SGD update engine.
// SGD_SAT_EN selects a saturating update instead of two's-complement wrap.
package sgd_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned FRAC_W = 8;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} sgd_state_e;

  // Q8.8 * Q8.8 -> Q16.16; the arithmetic shift keeps bits [23:8] (floor)
  function automatic logic [DATA_W-1:0] sgd_scale(input logic [DATA_W-1:0] lr,
                                                  input logic [DATA_W-1:0] g);
    logic signed [2*DATA_W-1:0] prod;
    prod = $signed(lr) * $signed(g);
    return DATA_W'(prod >>> FRAC_W);
  endfunction

  // Same slice, but clamped to the 16-bit signed range instead of truncated
  function automatic logic [DATA_W-1:0] sgd_scale_sat(input logic [DATA_W-1:0] lr,
                                                      input logic [DATA_W-1:0] g);
    logic signed [2*DATA_W-1:0] sh;
    sh = ($signed(lr) * $signed(g)) >>> FRAC_W;
    if (sh > 32'sd32767) return 16'h7FFF;
    if (sh < -32'sd32768) return 16'h8000;
    return sh[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] sat16(input logic signed [DATA_W:0] x);
    if (x > 17'sd32767) return 16'h7FFF;
    if (x < -17'sd32768) return 16'h8000;
    return x[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/sgd_pe.sv
// Two-stage multiply-subtract lane: S1 registers lr*g slice, p and address; S2 drives the write.
// SGD_SAT_EN defined: slice and difference are clamped rather than wrapped.
module sgd_pe
  import sgd_pkg::*;
#(
  parameter int unsigned AddrW = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] lr_i,
  input  logic [DATA_W-1:0] p_i,
  input  logic [DATA_W-1:0] g_i,
  input  logic              valid_i,
  input  logic [AddrW-1:0]  addr_i,
  output logic              wr_en_o,
  output logic [AddrW-1:0]  wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o
);

  logic              valid_q;
  logic [AddrW-1:0]  addr_q;
  logic [DATA_W-1:0] p_q;
  logic [DATA_W-1:0] scale_d, scale_q;

  always_comb begin
`ifdef SGD_SAT_EN
    scale_d = sgd_scale_sat(lr_i, g_i);
`else
    scale_d = sgd_scale(lr_i, g_i);
`endif
  end

  // Data registers only load on valid beats so idle cycles do not toggle the lane
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      p_q     <= '0;
      scale_q <= '0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        addr_q  <= addr_i;
        p_q     <= p_i;
        scale_q <= scale_d;
      end
    end
  end

`ifdef SGD_SAT_EN
  logic signed [DATA_W:0] diff;
  always_comb begin
    diff      = $signed({p_q[DATA_W-1], p_q}) - $signed({scale_q[DATA_W-1], scale_q});
    wr_data_o = sat16(diff);
  end
`else
  always_comb begin
    wr_data_o = p_q - scale_q;
  end
`endif

  assign wr_en_o   = valid_q;
  assign wr_addr_o = addr_q;

endmodule

// File: rtl/sgd_update_sched.sv
// Sequential SGD update scheduler: streams all parameters through one sgd_pe lane.
// SGD_SAT_EN (see sgd_pe) selects saturating updates.
module sgd_update_sched
  import sgd_pkg::*;
#(
  parameter int unsigned NUM_PARAMS = 13,
  parameter int unsigned ADDR_W     = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] lr,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] p_rdata,
  input  logic [DATA_W-1:0] g_rdata,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_PARAMS - 1);

  sgd_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] lr_q, lr_d;
  logic              rd_q;
  logic [ADDR_W-1:0] raddr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      lr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lr_q    <= lr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lr_d    = lr_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          cnt_d   = '0;
          lr_d    = lr;
        end
      end
      StRun: begin
        if (cnt_q == LastAddr) state_d = StDrain;
        else cnt_d = cnt_q + 1'b1;
      end
      StDrain: begin
        if (wr_en && (wr_addr == LastAddr)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_en   = (state_q == StRun);
    rd_addr = rd_en ? cnt_q : '0;
    busy    = (state_q != StIdle);
    done    = (state_q == StDone);
  end

  // RAM data arrives one cycle after the strobe; align valid/address with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= 1'b0;
      raddr_q <= '0;
    end else begin
      rd_q    <= rd_en;
      raddr_q <= rd_addr;
    end
  end

  sgd_pe #(
    .AddrW (ADDR_W)
  ) u_pe (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .lr_i      (lr_q),
    .p_i       (p_rdata),
    .g_i       (g_rdata),
    .valid_i   (rd_q),
    .addr_i    (raddr_q),
    .wr_en_o   (wr_en),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data)
  );

endmodule
